// File: rtl/show_2c_seq_pkg.sv
// ---------------------------------------------------------------------------
// show_2c_pkg
// Shared types and constants for the sequential two's-complement-to-BCD
// converter (show_2c_seq) and its add-3 digit cell.
//   state_t        : converter FSM states (IDLE, SHIFT, DONE)
//   BCD_W          : bits per BCD digit
//   ADD3_THRESH    : digit value at or above which double-dabble adds 3
//   min_digits()   : smallest digit count able to show every WIDTH-bit
//                    unsigned value (smallest d with 10^d > 2^width)
// ---------------------------------------------------------------------------
package show_2c_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int               BCD_W       = 4;
    localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;

    // Bounded loop keeps this usable as a constant function; 12 passes
    // covers 10^12 > 2^32, the largest legal width.
    function automatic int min_digits(input int width);
        longint pow2;
        longint pow10;
        int     d;
        pow2  = longint'(1) << width;
        pow10 = 10;
        d     = 1;
        for (int i = 0; i < 12; i++) begin
            if (pow10 <= pow2) begin
                pow10 = pow10 * 10;
                d     = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/show_2c_seq_bcd_add3_digit.sv
// ---------------------------------------------------------------------------
// bcd_add3_digit
// Combinational double-dabble correction for one BCD digit: adds 3 when the
// digit is 5 or more so the following left shift carries into the next digit.
//   digit    in  4  current BCD digit
//   adjusted out 4  digit after the conditional +3
// ---------------------------------------------------------------------------
module bcd_add3_digit
    import show_2c_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] adjusted
);

    assign adjusted = (digit >= ADD3_THRESH) ? digit + 4'd3 : digit;

endmodule

// File: rtl/show_2c_seq.sv
// ---------------------------------------------------------------------------
// show_2c_seq
// Sequential WIDTH-bit (signed or unsigned) to DIGITS-digit packed BCD
// converter using a one-bit-per-cycle shift-add-3 engine.
//   clk        in   1         system clock, rising edge
//   reset_n    in   1         synchronous active-low reset
//   start      in   1         conversion request, honoured only in IDLE
//   is_signed  in   1         Din is two's complement when 1
//   Din        in   WIDTH     value to convert, sampled with start
//   busy       out  1         conversion in progress
//   done       out  1         one-cycle pulse when Dout/sign update
//   Dout       out  4*DIGITS  packed BCD magnitude, digit 0 in [3:0]
//   sign       out  1         converted value was negative
//   fsm_state  out  state_t   current FSM state (observation only)
//
// Handshake: start is a level sampled on each rising edge while the FSM is
// in IDLE; it has no ready/ack. busy rises after the accepting edge and falls
// together with the single-cycle done pulse WIDTH+1 edges later. start seen
// while busy is dropped, never queued.
// ---------------------------------------------------------------------------
module show_2c_seq
    import show_2c_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    is_signed,
    input  logic [WIDTH-1:0]        Din,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] Dout,
    output logic                    sign,
    output state_t                  fsm_state
);

    localparam int BW = BCD_W * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("show_2c_seq: WIDTH must be 2..32");
    end
    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
        $error("show_2c_seq: DIGITS too small, need 10^DIGITS > 2^WIDTH");
    end

    state_t          state;
    state_t          state_n;
    logic [WIDTH-1:0] mag;
    logic [BW-1:0]    bcd;
    logic [BW-1:0]    bcd_adj;
    logic [CW-1:0]    count;
    logic             neg;
    logic             load_neg;
    logic [WIDTH-1:0] load_mag;

    // Negating the most-negative value yields 2^(WIDTH-1), which still fits
    // in WIDTH unsigned bits, so no special case is required.
    assign load_neg = is_signed & Din[WIDTH-1];
    assign load_mag = load_neg ? (~Din + WIDTH'(1)) : Din;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_add3_digit u_add3 (
            .digit    (bcd[BCD_W*i +: BCD_W]),
            .adjusted (bcd_adj[BCD_W*i +: BCD_W])
        );
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = SHIFT;
            // count holds the number of shifts still to do, including this one
            SHIFT:   if (count == CW'(1)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            mag   <= '0;
            bcd   <= '0;
            count <= '0;
            neg   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Dout  <= '0;
            sign  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        neg   <= load_neg;
                        mag   <= load_mag;
                        bcd   <= '0;
                        count <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    {bcd, mag} <= {bcd_adj, mag} << 1;
                    count      <= count - CW'(1);
                end
                DONE: begin
                    Dout <= bcd;
                    sign <= neg;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign fsm_state = state;

endmodule
